regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to zero.
REQ-005 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port RA, input, NRD*ADDR_W, read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port RD, output, NRD*DATA_W, read data; slice k corresponds to RA slice k.
REQ-009 SHALL have port RBusy, output, NRD, per-read-port flag: the addressed register has a pending reservation.
REQ-010 SHALL have ports WE0/WA0/WD0, input, 1/ADDR_W/DATA_W, write port 0.
REQ-011 SHALL have ports WE1/WA1/WD1, input, 1/ADDR_W/DATA_W, write port 1.
REQ-012 SHALL have ports ResE/ResA, input, 1/ADDR_W, reservation request (marks destination of an outstanding load).

Function
REQ-013 Reads SHALL be combinational: RD[k] = Registers[RA[k]]; RBusy[k] = Busy[RA[k]].
REQ-014 On a rising Clk edge with WEn=1, Registers[WAn] SHALL take WDn; the write and Busy[WAn] <= 0 take effect together.
REQ-015 When WE0=WE1=1 and WA0=WA1, port 1 SHALL win; register gets WD1.
REQ-016 When ZERO_REG=1, writes and reservations to address 0 SHALL be ignored; RD SHALL read 0 and RBusy 0 for address 0.
REQ-017 When ZERO_REG=0, address 0 SHALL behave as an ordinary register.
REQ-018 On a rising edge with ResE=1, Busy[ResA] SHALL be set to 1.
REQ-019 Reservation and write to the same address in the same cycle SHALL leave Busy=1 (reserve wins); the register data SHALL still update.
REQ-020 Writes to distinct addresses on both ports SHALL both complete in the same cycle.
REQ-021 Write latency SHALL be one edge: data readable from the cycle after the write edge (without bypass).
REQ-022 All address values 0..2^ADDR_W-1 SHALL be valid; no wrap-around or out-of-range handling needed.

Reset
REQ-023 Rst_n=0 SHALL asynchronously clear all Registers to 0 and all Busy bits to 0, regardless of Clk.
REQ-024 While Rst_n=0, RD SHALL be all-zero and RBusy all-zero; writes and reservations SHALL be ignored.
REQ-025 Deassertion of Rst_n SHALL take effect at the next rising Clk edge; a write presented on that edge SHALL complete.

Configuration
REQ-026 Macro REGFILE_MP_BYPASS_EN SHALL enable write-through forwarding.
REQ-027 With REGFILE_MP_BYPASS_EN defined: if WEn=1 and WAn=RA[k] (address 0 excluded when ZERO_REG=1), RD[k] SHALL show WDn in the same cycle (port 1 priority), and RBusy[k] SHALL read 0 unless ResE=1 with ResA=RA[k].
REQ-028 Without REGFILE_MP_BYPASS_EN: RD and RBusy SHALL reflect stored state only; same-cycle write is visible next cycle.

Verification
REQ-029 Reset: write 0xDEADBEEF to r5, assert Rst_n=0 mid-cycle -> RD for RA=5 reads 0x00000000 immediately, RBusy=0.
REQ-030 Dual write: WA0=3/WD0=0x11, WA1=4/WD1=0x22 same edge -> next cycle r3=0x11, r4=0x22; conflict WA0=WA1=7 with 0xAA/0xBB -> r7=0xBB.
REQ-031 Zero register (ZERO_REG=1): write 0x12345678 to r0, ResE on r0 -> RD=0, RBusy=0; with ZERO_REG=0 -> RD=0x12345678.
REQ-032 Scoreboard: ResE ResA=9 -> RBusy=1 for RA=9 next cycle; WE0 WA0=9 WD0=0x55 -> RBusy=0, RD=0x55; simultaneous ResE+WE on r9 -> RBusy stays 1.
REQ-033 Bypass: RA[0]=6, WE1 WA1=6 WD1=0xCAFE -> with macro RD[0]=0xCAFE same cycle; without macro old value until next cycle.
REQ-034 Parameter sweep: DATA_W=16, ADDR_W=3, NRD=4 -> write/read all 8 registers on all 4 ports; values match written data.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (port 1 wins),
// per-register busy scoreboard. Define REGFILE_MP_BYPASS_EN for write-through forwarding.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NRD*ADDR_W-1:0]    RA,
  output logic [NRD*DATA_W-1:0]    RD,
  output logic [NRD-1:0]           RBusy,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WA0,
  input  logic [DATA_W-1:0]        WD0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WA1,
  input  logic [DATA_W-1:0]        WD1,
  input  logic                     ResE,
  input  logic [ADDR_W-1:0]        ResA
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic              we0_ok, we1_ok, res_ok;

  // Address 0 is read-only when hardwired to zero.
  always_comb begin
    we0_ok = WE0  && !(ZERO_REG != 0 && WA0  == '0);
    we1_ok = WE1  && !(ZERO_REG != 0 && WA1  == '0);
    res_ok = ResE && !(ZERO_REG != 0 && ResA == '0);
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we0_ok) begin
      regs_d[WA0] = WD0;
      busy_d[WA0] = 1'b0;
    end
    if (we1_ok) begin
      regs_d[WA1] = WD1;
      busy_d[WA1] = 1'b0;
    end
    // Reservation applied last so it beats a same-cycle write completion.
    if (res_ok) begin
      busy_d[ResA] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              busy;

    assign ra = RA[g*ADDR_W +: ADDR_W];

    always_comb begin
      rd   = regs_q[ra];
      busy = busy_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (we1_ok && WA1 == ra) begin
        rd   = WD1;
        busy = res_ok && ResA == ra;
      end else if (we0_ok && WA0 == ra) begin
        rd   = WD0;
        busy = res_ok && ResA == ra;
      end
`endif
      if (!Rst_n || (ZERO_REG != 0 && ra == '0)) begin
        rd   = '0;
        busy = 1'b0;
      end
    end

    assign RD[g*DATA_W +: DATA_W] = rd;
    assign RBusy[g]               = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp: default, ZERO_REG=0 and 16/3/4 instances.
module tb_regfile_mp;

  logic        Clk;
  logic        Rst_n;
  logic [9:0]  ra;
  logic [63:0] rd, rd_nz;
  logic [1:0]  rbusy, rbusy_nz;
  logic        we0, we1, rese;
  logic [4:0]  wa0, wa1, resa;
  logic [31:0] wd0, wd1;

  logic [11:0] s_ra;
  logic [63:0] s_rd;
  logic [3:0]  s_rbusy;
  logic        s_we0, s_we1, s_rese;
  logic [2:0]  s_wa0, s_wa1, s_resa;
  logic [15:0] s_wd0, s_wd1;

  int checks   = 0;
  int failures = 0;

  regfile_mp dut (
    .Clk(Clk), .Rst_n(Rst_n), .RA(ra), .RD(rd), .RBusy(rbusy),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .ResE(rese), .ResA(resa)
  );

  regfile_mp #(.ZERO_REG(0)) dut_nz (
    .Clk(Clk), .Rst_n(Rst_n), .RA(ra), .RD(rd_nz), .RBusy(rbusy_nz),
    .WE0(we0), .WA0(wa0), .WD0(wd0), .WE1(we1), .WA1(wa1), .WD1(wd1),
    .ResE(rese), .ResA(resa)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .ZERO_REG(0)) dut_sw (
    .Clk(Clk), .Rst_n(Rst_n), .RA(s_ra), .RD(s_rd), .RBusy(s_rbusy),
    .WE0(s_we0), .WA0(s_wa0), .WD0(s_wd0), .WE1(s_we1), .WA1(s_wa1), .WD1(s_wd1),
    .ResE(s_rese), .ResA(s_resa)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        rese; logic [4:0] resa;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic        b0, b1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rese = 1'b0;
    s_we0 = 1'b0; s_we1 = 1'b0; s_rese = 1'b0;
  endtask

  function automatic logic [15:0] sw_exp(input int a);
    return 16'(16'hA000 + a * 16'h0111);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 5'd0,
                5'd3,  5'd4,  32'h11,       32'h22,       1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd7,  32'hAA,       1'b1, 5'd7,  32'hBB,       1'b0, 5'd0,
                5'd7,  5'd3,  32'hBB,       32'h11,       1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,
                5'd0,  5'd7,  32'h0,        32'hBB,       1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,
                5'd9,  5'd7,  32'h0,        32'hBB,       1'b1, 1'b0};
    vecs[4] = '{1'b1, 5'd9,  32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 5'd0,
                5'd9,  5'd0,  32'h55,       32'h0,        1'b0, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h66,       1'b1, 5'd9,
                5'd9,  5'd9,  32'h66,       32'h66,       1'b1, 1'b1};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd30, 32'hA5A5A5A5, 1'b0, 5'd0,
                5'd31, 5'd30, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 5'd30, 32'h1234,     1'b0, 5'd0,  32'h0,        1'b1, 5'd31,
                5'd31, 5'd30, 32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0};

    Rst_n = 1'b0; ra = '0; wa0 = '0; wa1 = '0; resa = '0; wd0 = '0; wd1 = '0;
    s_ra = '0; s_wa0 = '0; s_wa1 = '0; s_resa = '0; s_wd0 = '0; s_wd1 = '0;
    idle();
    ra[4:0] = 5'd5; ra[9:5] = 5'd9;
    #1;
    chk("reset rd", rd, 64'h0);
    chk("reset rbusy", {62'h0, rbusy}, 64'h0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      rese = vecs[i].rese; resa = vecs[i].resa;
      @(posedge Clk);
      #1;
      idle();
      ra = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk($sformatf("vec%0d rd0", i), {32'h0, rd[31:0]}, {32'h0, vecs[i].e0});
      chk($sformatf("vec%0d rd1", i), {32'h0, rd[63:32]}, {32'h0, vecs[i].e1});
      chk($sformatf("vec%0d busy0", i), {63'h0, rbusy[0]}, {63'h0, vecs[i].b0});
      chk($sformatf("vec%0d busy1", i), {63'h0, rbusy[1]}, {63'h0, vecs[i].b1});
    end

    // Ordinary register 0 when not hardwired.
    ra[4:0] = 5'd0;
    #1;
    chk("nz r0 data", {32'h0, rd_nz[31:0]}, 64'h12345678);
    chk("nz r0 busy", {63'h0, rbusy_nz[0]}, 64'h1);

    // Same-cycle forwarding from write port 1.
    @(negedge Clk);
    ra = {5'd6, 5'd6};
    we1 = 1'b1; wa1 = 5'd6; wd1 = 32'hCAFE;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass same-cycle rd0", {32'h0, rd[31:0]}, 64'hCAFE);
`else
    chk("no-bypass same-cycle rd0", {32'h0, rd[31:0]}, 64'h0);
`endif
    chk("bypass same-cycle busy0", {63'h0, rbusy[0]}, 64'h0);
    @(posedge Clk); #1; idle(); #1;
    chk("bypass next-cycle rd0", {32'h0, rd[31:0]}, 64'hCAFE);

    // Forwarded write together with a reservation on the same register.
    @(negedge Clk);
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'hBEEF; rese = 1'b1; resa = 5'd6;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass res rd1", {32'h0, rd[63:32]}, 64'hBEEF);
    chk("bypass res busy1", {63'h0, rbusy[1]}, 64'h1);
`else
    chk("no-bypass res rd1", {32'h0, rd[63:32]}, 64'hCAFE);
    chk("no-bypass res busy1", {63'h0, rbusy[1]}, 64'h0);
`endif
    @(posedge Clk); #1; idle(); #1;
    chk("res+write rd1", {32'h0, rd[63:32]}, 64'hBEEF);
    chk("res+write busy1", {63'h0, rbusy[1]}, 64'h1);

    // Writing r0 never forwards when hardwired.
    @(negedge Clk);
    ra[4:0] = 5'd0; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h77;
    #1;
    chk("zero bypass rd0", {32'h0, rd[31:0]}, 64'h0);
    @(posedge Clk); #1; idle();

    // Asynchronous reset mid-cycle.
    @(negedge Clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    @(posedge Clk); #1; idle();
    ra = {5'd9, 5'd5};
    #1;
    chk("pre-reset r5", {32'h0, rd[31:0]}, 64'hDEADBEEF);
    chk("pre-reset busy r9", {63'h0, rbusy[1]}, 64'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async reset rd", rd, 64'h0);
    chk("async reset rbusy", {62'h0, rbusy}, 64'h0);
    @(negedge Clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111; rese = 1'b1; resa = 5'd5;
    @(posedge Clk); #1; idle(); #1;
    chk("write in reset rd0", {32'h0, rd[31:0]}, 64'h0);
    chk("res in reset busy0", {63'h0, rbusy[0]}, 64'h0);

    // Release reset with a write on the first active edge.
    @(negedge Clk);
    Rst_n = 1'b1;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h2222;
    @(posedge Clk); #1; idle(); #1;
    chk("post-reset write r5", {32'h0, rd[31:0]}, 64'h2222);
    chk("post-reset r9 cleared", {32'h0, rd[63:32]}, 64'h0);
    chk("post-reset busy r9", {63'h0, rbusy[1]}, 64'h0);

    // Parameter sweep: fill all 8 entries, read back on all 4 ports.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      s_we0 = 1'b1; s_wa0 = 3'(2 * i);     s_wd0 = sw_exp(2 * i);
      s_we1 = 1'b1; s_wa1 = 3'(2 * i + 1); s_wd1 = sw_exp(2 * i + 1);
      @(posedge Clk); #1; idle();
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) s_ra[k*3 +: 3] = 3'((i + k) % 8);
      #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sweep a%0d p%0d", (i + k) % 8, k), {48'h0, s_rd[k*16 +: 16]},
            {48'h0, sw_exp((i + k) % 8)});
      end
      chk($sformatf("sweep busy i%0d", i), {60'h0, s_rbusy}, 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
